// File: rtl/alu_dec_adjust.sv
// Post-adder stage of the 65C02 ALU datapath.
// Turns the raw adder sum/carry vectors into the final result and N/V/Z/C flags.
// Decimal-mode ADC/SBC spend one extra cycle in StAdj applying the BCD correction.
// Handshake: one operation in flight; a new one is accepted only from StIdle.
module alu_dec_adjust (
  input  logic       clk,
  input  logic       RST_N,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] SUM,
  input  logic [7:0] CARRY,
  input  logic [7:0] O6,
  input  logic       SUB,
  input  logic       DEC,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] RES,
  output logic       N,
  output logic       V,
  output logic       Z,
  output logic       C,
  output logic [7:0] O6_Q
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAdj  = 2'd1,
    StDone = 2'd2
  } state_e;

  state_e state_q, state_d;

  // Operands held for the decimal correction cycle. Only the half carry and the
  // carry out matter to the correction, so the other carry bits are not kept.
  logic [7:0] sum_q;
  logic       hc_q;
  logic       c7_q;
  logic       sub_q;

  logic [7:0] res_q;
  logic       n_q, v_q, z_q, c_q;
  logic [7:0] o6_q;

  logic       accept;
  logic       lo_fix, hi_fix;
  logic [7:0] adj;
  logic [7:0] dec_res;
  logic       dec_c;

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign accept    = in_ready & in_valid;

  assign RES  = res_q;
  assign N    = n_q;
  assign V    = v_q;
  assign Z    = z_q;
  assign C    = c_q;
  assign O6_Q = o6_q;

  // Next-state logic: decimal ops detour through StAdj, binary ops go straight to StDone.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          state_d = DEC ? StAdj : StDone;
        end
      end
      StAdj: begin
        state_d = StDone;
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // BCD correction on the held binary sum. For SBC the carries are inverted
  // borrows, so a clear carry means that digit borrowed and needs -6.
  always_comb begin
    lo_fix  = 1'b0;
    hi_fix  = 1'b0;
    adj     = 8'h00;
    dec_res = sum_q;
    dec_c   = c7_q;
    if (sub_q) begin
      lo_fix  = ~hc_q;
      hi_fix  = ~c7_q;
      adj     = {(hi_fix ? 4'h6 : 4'h0), (lo_fix ? 4'h6 : 4'h0)};
      dec_res = sum_q - adj;
      dec_c   = c7_q;
    end else begin
      lo_fix  = hc_q | (sum_q[3:0] > 4'd9);
      hi_fix  = c7_q | (sum_q > 8'h99);
      adj     = {(hi_fix ? 4'h6 : 4'h0), (lo_fix ? 4'h6 : 4'h0)};
      dec_res = sum_q + adj;
      dec_c   = hi_fix;
    end
  end

  // State, operand capture and result registers. On accept the binary result is
  // loaded directly; a decimal op then overwrites RES/N/Z/C in StAdj while V
  // keeps the binary-sum overflow.
  always_ff @(posedge clk) begin
    if (!RST_N) begin
      state_q <= StIdle;
      sum_q   <= 8'h00;
      hc_q    <= 1'b0;
      c7_q    <= 1'b0;
      sub_q   <= 1'b0;
      res_q   <= 8'h00;
      n_q     <= 1'b0;
      v_q     <= 1'b0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      o6_q    <= 8'h00;
    end else begin
      state_q <= state_d;
      if (accept) begin
        sum_q <= SUM;
        hc_q  <= CARRY[3];
        c7_q  <= CARRY[7];
        sub_q <= SUB;
        o6_q  <= O6;
        res_q <= SUM;
        n_q   <= SUM[7];
        z_q   <= (SUM == 8'h00);
        c_q   <= CARRY[7];
        v_q   <= CARRY[7] ^ CARRY[6];
      end else if (state_q == StAdj) begin
        res_q <= dec_res;
        n_q   <= dec_res[7];
        z_q   <= (dec_res == 8'h00);
        c_q   <= dec_c;
      end
    end
  end

endmodule

// File: tb/tb_alu_dec_adjust.sv
// Directed testbench for alu_dec_adjust: binary and decimal vectors, latency,
// backpressure, reset during an operation and back-to-back issue.
module tb_alu_dec_adjust;

  logic       clk;
  logic       RST_N;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] SUM;
  logic [7:0] CARRY;
  logic [7:0] O6;
  logic       SUB;
  logic       DEC;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] RES;
  logic       N, V, Z, C;
  logic [7:0] O6_Q;

  int pass_cnt = 0;
  int total_cnt = 0;

  alu_dec_adjust dut (
    .clk      (clk),
    .RST_N    (RST_N),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .SUM      (SUM),
    .CARRY    (CARRY),
    .O6       (O6),
    .SUB      (SUB),
    .DEC      (DEC),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .RES      (RES),
    .N        (N),
    .V        (V),
    .Z        (Z),
    .C        (C),
    .O6_Q     (O6_Q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] s, input logic [7:0] c, input logic [7:0] o6,
                       input logic sub, input logic dec);
    in_valid = 1'b1;
    SUM = s;
    CARRY = c;
    O6 = o6;
    SUB = sub;
    DEC = dec;
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b0;
    SUM = 8'h55; CARRY = 8'hAA; O6 = 8'h3C; SUB = 1'b0; DEC = 1'b0;
    tick();
    tick();
    total_cnt++;
    if ({out_valid, in_ready} !== 2'b01) begin
      $display("FAIL reset_hs: got valid/ready=%b expected 01", {out_valid, in_ready});
    end else pass_cnt++;
    total_cnt++;
    if ({RES, N, V, Z, C, O6_Q} !== 20'h0) begin
      $display("FAIL reset_out: got %h expected 00000", {RES, N, V, Z, C, O6_Q});
    end else pass_cnt++;
    in_valid = 1'b0;
    RST_N = 1'b1;
    tick();
  endtask

  task automatic test_binary();
    drive(8'h80, 8'h7F, 8'hA5, 1'b0, 1'b0);
    tick();
    in_valid = 1'b0;
    total_cnt++;
    if ({out_valid, in_ready} !== 2'b10) begin
      $display("FAIL bin_latency: got valid/ready=%b expected 10", {out_valid, in_ready});
    end else pass_cnt++;
    total_cnt++;
    if ({RES, N, V, Z, C} !== {8'h80, 4'b1100}) begin
      $display("FAIL bin_7f_01: got %h expected %h", {RES, N, V, Z, C}, {8'h80, 4'b1100});
    end else pass_cnt++;
    total_cnt++;
    if (O6_Q !== 8'hA5) begin
      $display("FAIL bin_o6q: got %h expected a5", O6_Q);
    end else pass_cnt++;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total_cnt++;
    if ({out_valid, in_ready} !== 2'b01) begin
      $display("FAIL bin_handoff: got valid/ready=%b expected 01", {out_valid, in_ready});
    end else pass_cnt++;
  endtask

  // One decimal op: checks the extra ADJ cycle, then the corrected result.
  task automatic run_dec(input string name, input logic [7:0] s, input logic [7:0] c,
                         input logic sub, input logic [11:0] exp);
    drive(s, c, 8'h00, sub, 1'b1);
    tick();
    in_valid = 1'b0;
    total_cnt++;
    if ({out_valid, in_ready} !== 2'b00) begin
      $display("FAIL %s_adj: got valid/ready=%b expected 00", name, {out_valid, in_ready});
    end else pass_cnt++;
    tick();
    total_cnt++;
    if (out_valid !== 1'b1) begin
      $display("FAIL %s_latency: got out_valid=%b expected 1", name, out_valid);
    end else pass_cnt++;
    total_cnt++;
    if ({RES, N, V, Z, C} !== exp) begin
      $display("FAIL %s: got %h expected %h", name, {RES, N, V, Z, C}, exp);
    end else pass_cnt++;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_decimal();
    run_dec("dec_09_01", 8'h0A, 8'h01, 1'b0, {8'h10, 4'b0000});
    run_dec("dec_99_01", 8'h9A, 8'h01, 1'b0, {8'h00, 4'b0011});
    run_dec("dec_10_m01", 8'h0F, 8'hF0, 1'b1, {8'h09, 4'b0001});
    run_dec("dec_00_m01", 8'hFF, 8'h00, 1'b1, {8'h99, 4'b1000});
  endtask

  task automatic test_backpressure();
    drive(8'h00, 8'hFF, 8'h11, 1'b0, 1'b0);
    tick();
    // Keep offering a different op while the result is held.
    drive(8'h42, 8'h00, 8'h99, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      total_cnt++;
      if ({out_valid, in_ready, RES, N, V, Z, C, O6_Q} !== {2'b10, 8'h00, 4'b0011, 8'h11}) begin
        $display("FAIL bp_hold%0d: got %h expected %h", i,
                 {out_valid, in_ready, RES, N, V, Z, C, O6_Q}, {2'b10, 8'h00, 4'b0011, 8'h11});
      end else pass_cnt++;
      tick();
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    out_ready = 1'b0;
    total_cnt++;
    if ({out_valid, in_ready, RES, O6_Q} !== {2'b01, 8'h00, 8'h11}) begin
      $display("FAIL bp_release: got %h expected %h", {out_valid, in_ready, RES, O6_Q},
               {2'b01, 8'h00, 8'h11});
    end else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    drive(8'h9A, 8'h01, 8'h77, 1'b0, 1'b1);
    tick();
    in_valid = 1'b0;
    RST_N = 1'b0;
    tick();
    RST_N = 1'b1;
    total_cnt++;
    if ({out_valid, in_ready, RES, N, V, Z, C, O6_Q} !== {2'b01, 20'h0}) begin
      $display("FAIL reset_mid: got %h expected %h", {out_valid, in_ready, RES, N, V, Z, C, O6_Q},
               {2'b01, 20'h0});
    end else pass_cnt++;
    drive(8'h7E, 8'h00, 8'h3C, 1'b0, 1'b0);
    tick();
    in_valid = 1'b0;
    total_cnt++;
    if ({out_valid, RES, N, V, Z, C, O6_Q} !== {1'b1, 8'h7E, 4'b0000, 8'h3C}) begin
      $display("FAIL reset_mid_after: got %h expected %h", {out_valid, RES, N, V, Z, C, O6_Q},
               {1'b1, 8'h7E, 4'b0000, 8'h3C});
    end else pass_cnt++;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int budget;
    out_ready = 1'b1;
    drive(8'hC0, 8'h80, 8'h01, 1'b0, 1'b0);
    tick();
    total_cnt++;
    if ({out_valid, RES, N, V, Z, C} !== {1'b1, 8'hC0, 4'b1101}) begin
      $display("FAIL b2b_first: got %h expected %h", {out_valid, RES, N, V, Z, C},
               {1'b1, 8'hC0, 4'b1101});
    end else pass_cnt++;
    drive(8'h01, 8'h40, 8'h02, 1'b0, 1'b0);
    tick();
    total_cnt++;
    if ({out_valid, in_ready} !== 2'b01) begin
      $display("FAIL b2b_gap: got valid/ready=%b expected 01", {out_valid, in_ready});
    end else pass_cnt++;
    tick();
    in_valid = 1'b0;
    budget = 0;
    while (out_valid !== 1'b1 && budget < 10) begin
      tick();
      budget++;
    end
    total_cnt++;
    if (budget != 0 || {RES, N, V, Z, C, O6_Q} !== {8'h01, 4'b0100, 8'h02}) begin
      $display("FAIL b2b_second: got %h after %0d extra cycles expected %h with 0",
               {RES, N, V, Z, C, O6_Q}, budget, {8'h01, 4'b0100, 8'h02});
    end else pass_cnt++;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    in_valid = 1'b0;
    out_ready = 1'b0;
    RST_N = 1'b0;
    SUM = 8'h00; CARRY = 8'h00; O6 = 8'h00; SUB = 1'b0; DEC = 1'b0;
    test_reset();
    test_binary();
    test_decimal();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/alu_dec_adjust.md
Name: alu_dec_adjust

Overview:
- Post-adder stage of the 65C02 ALU datapath.
- Consumes the sum, per-bit carry vector and XOR vector produced by the 8-bit LUT/carry-chain adder.
- Produces the final ALU result and the N, V, Z, C flags.
- Performs decimal (BCD) correction for ADC/SBC in decimal mode, with one extra cycle, as on the 65C02. Valid/ready handshake on both sides.

Parameters:
- NONE (fixed 8-bit datapath)

Ports:
- clk  in  1  clock
- RST_N  in  1  synchronous active-low reset
- in_valid  in  1  input operation valid
- in_ready  out  1  block can accept an operation
- SUM  in  8  adder sum output
- CARRY  in  8  adder carry-out of each bit; [3] = half carry, [7] = carry out
- O6  in  8  adder propagate (I0^I1) vector; registered only, for flag debug
- SUB  in  1  1 = subtraction (SBC); carries are inverted borrows
- DEC  in  1  1 = decimal mode
- out_valid  out  1  result/flags valid
- out_ready  in  1  consumer accepts result
- RES  out  8  final result
- N  out  1  negative flag
- V  out  1  overflow flag
- Z  out  1  zero flag
- C  out  1  carry flag
- O6_Q  out  8  registered O6

Behaviour:
- Reset (RST_N=0 at rising clk): state=IDLE, out_valid=0, RES=0, N=V=Z=C=0, O6_Q=0.
- Reset overrides everything, including an operation in ADJ or DONE; that operation is discarded.
- in_ready = (state==IDLE). It is a combinational function of state only.
- FSM states: IDLE, ADJ, DONE.
- IDLE: on in_valid (accept):
  - Capture SUM, CARRY, O6, SUB, DEC.
  - DEC=0: next state DONE.
  - DEC=1: next state ADJ.
  - No accept: stay in IDLE.
- ADJ: compute the decimal correction; always go to DONE next cycle.
- DONE: out_valid=1. Go to IDLE on out_ready=1; otherwise hold.
  - RES/flags are stable while held.
  - in_ready stays 0, so no new operation is accepted in the same cycle as the output handoff.
- Latency from accept edge to out_valid=1:
  - binary: 1 cycle
  - decimal: 2 cycles
- Peak throughput:
  - binary: 1 op per 2 cycles
  - decimal: 1 op per 3 cycles
- Binary (DEC=0):
  - RES=SUM
  - C=CARRY[7]
  - V=CARRY[7]^CARRY[6]
  - N=SUM[7]
  - Z=(SUM==0)
- Decimal add (DEC=1, SUB=0):
  - lo_fix = CARRY[3] | (SUM[3:0]>9)
  - hi_fix = CARRY[7] | (SUM>8'h99)
  - RES = SUM + (lo_fix?8'h06:0) + (hi_fix?8'h60:0), mod 256
  - C = hi_fix
- Decimal sub (DEC=1, SUB=1):
  - lo_fix = ~CARRY[3]
  - hi_fix = ~CARRY[7]
  - RES = SUM - (lo_fix?8'h06:0) - (hi_fix?8'h60:0), mod 256
  - C = CARRY[7]
- Decimal V = CARRY[7]^CARRY[6], taken from the binary sum.
- Decimal N and Z are computed from the corrected RES (65C02 semantics).
- All arithmetic is 8-bit with wrap-around; no other saturation.
- Invalid BCD inputs are not special-cased; the formulas above apply.
- O6_Q updates only on accept.
- in_valid while in_ready=0 is ignored; the producer must hold its inputs.

Test Plan:
- Binary 7F+01: SUM=80, CARRY=7F, DEC=0, SUB=0 -> out_valid 1 cycle after accept; RES=80, N=1, V=1, Z=0, C=0.
- Decimal 09+01: SUM=0A, CARRY=01, DEC=1, SUB=0 -> out_valid 2 cycles after accept; RES=10, C=0, Z=0, N=0.
- Decimal 99+01: SUM=9A, CARRY=01, DEC=1, SUB=0 -> RES=00, C=1, Z=1, N=0.
- Decimal 10-01 (adder 10+FE+1): SUM=0F, CARRY=F0, DEC=1, SUB=1 -> RES=09, C=1, Z=0.
- Backpressure: hold out_ready=0 for 3 cycles after out_valid -> RES/flags stable, in_ready=0, new in_valid ignored; out_ready=1 -> IDLE next cycle, in_ready=1.
- Reset mid-operation: assert RST_N=0 during ADJ -> next edge: state=IDLE, out_valid=0, all outputs 0; a following binary op completes normally.
